// File: rtl/stark_sau_issue_arb_if.sv
// Issue-side bundle between the reservation stations and the SAU issue arbiter.
// Latency: none, wires only.
// Backpressure: grant is the only dequeue strobe; busy_o tells requesters that no grant can come.
//
// Signals:
//   req_v/req_rse/req_rndx/req_mc/req_prio  per-requester request, payload, ROB index, op class, urgency
//   grant                                   one-hot combinational grant, requester dequeues on it
//   stomp                                   ROB stomp mask, one bit per ROB index
//   wb_ret                                  one writeback buffer slot freed this cycle
//   sau_v_o/sau_rse_o/sau_rndx_o            registered entry towards the SAU
//   busy_o                                  arbiter cannot issue (multi-cycle op active or no credit)
interface stark_sau_issue_arb_if #(
    parameter int NREQ  = 4,
    parameter int RSEW  = 256,
    parameter int RNDXW = 5
);
    logic [NREQ-1:0]       req_v;
    logic [NREQ*RSEW-1:0]  req_rse;
    logic [NREQ*RNDXW-1:0] req_rndx;
    logic [NREQ-1:0]       req_mc;
    logic [NREQ-1:0]       req_prio;
    logic [NREQ-1:0]       grant;
    logic [2**RNDXW-1:0]   stomp;
    logic                  wb_ret;
    logic                  sau_v_o;
    logic [RSEW-1:0]       sau_rse_o;
    logic [RNDXW-1:0]      sau_rndx_o;
    logic                  busy_o;

    // Requester / environment side
    modport master (
        output req_v, req_rse, req_rndx, req_mc, req_prio, stomp, wb_ret,
        input  grant, sau_v_o, sau_rse_o, sau_rndx_o, busy_o
    );

    // Arbiter side
    modport slave (
        input  req_v, req_rse, req_rndx, req_mc, req_prio, stomp, wb_ret,
        output grant, sau_v_o, sau_rse_o, sau_rndx_o, busy_o
    );
endinterface

// File: rtl/stark_sau_issue_arb.sv
// Round-robin issue arbiter in front of the Stark meta SAU: picks one request per cycle.
// Latency: grant is combinational, the SAU entry is registered one cycle after grant.
// Backpressure: no grant while a multi-cycle op occupies the SAU or no writeback credit is left.
//
// Ports:
//   clk   clock
//   rst   synchronous reset, active low
//   bus   stark_sau_issue_arb_if.slave (requests, stomp, wb_ret in; grant, SAU entry, busy out)
// Optional feature: define STARK_SAU_ARB_PRIO_EN to let req_prio requests win over normal ones.
module stark_sau_issue_arb #(
    parameter int NREQ    = 4,
    parameter int RSEW    = 256,
    parameter int RNDXW   = 5,
    parameter int MCLAT   = 8,
    parameter int CREDITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    stark_sau_issue_arb_if.slave  bus
);
    localparam int PTRW = $clog2(NREQ);
    localparam int CNTW = $clog2(MCLAT);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PTRW-1:0]   r_rr_ptr;
    logic [2:0]        r_credit;
    logic [CNTW-1:0]   r_mc_cnt;
    logic [RNDXW-1:0]  r_mc_rndx;
    logic              r_sau_v;
    logic [RSEW-1:0]   r_sau_rse;
    logic [RNDXW-1:0]  r_sau_rndx;

    logic              w_issue_en;
    logic              w_busy;
    logic [NREQ-1:0]   w_elig;
    logic [PTRW:0]     w_pick_lo;
    logic [PTRW:0]     w_pick;
    logic              w_found;
    logic [PTRW-1:0]   w_win;
    logic [NREQ-1:0]   w_grant;
    logic [RNDXW-1:0]  w_win_rndx;

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    // Scanning from the farthest position back to ptr leaves the nearest hit.
    function automatic logic [PTRW:0] rr_pick(input logic [NREQ-1:0] elig,
                                              input logic [PTRW-1:0] ptr);
        logic [PTRW:0] res;
        int            idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (elig[idx]) res = {1'b1, PTRW'(idx)};
        end
        return res;
    endfunction

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM: next state. r_mc_cnt is loaded with MCLAT-1 and the wait ends on the
    // edge where it would count down to zero, so a multi-cycle grant at cycle T
    // blocks T+1..T+MCLAT-1 and the next grant can happen at T+MCLAT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_found && bus.req_mc[w_win]) w_state_nxt = ST_MC_WAIT;
            ST_MC_WAIT: if (bus.stomp[r_mc_rndx] || (r_mc_cnt == CNTW'(1)))
                            w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs. Grants are suppressed while reset is held.
    always_comb begin
        w_issue_en = rst && (r_state == ST_IDLE) && (r_credit != 3'd0);
        w_busy     = (r_state != ST_IDLE) || (r_credit == 3'd0);
    end

    always_comb begin
        w_elig = '0;
        for (int n = 0; n < NREQ; n++)
            w_elig[n] = bus.req_v[n] && !bus.stomp[bus.req_rndx[n*RNDXW +: RNDXW]] && w_issue_en;
    end

    assign w_pick_lo = rr_pick(w_elig, r_rr_ptr);

`ifdef STARK_SAU_ARB_PRIO_EN
    logic [PTRW:0] w_pick_hi;
    assign w_pick_hi = rr_pick(w_elig & bus.req_prio, r_rr_ptr);
    assign w_pick    = w_pick_hi[PTRW] ? w_pick_hi : w_pick_lo;
`else
    logic w_unused_prio;
    assign w_unused_prio = ^bus.req_prio;
    assign w_pick        = w_pick_lo;
`endif

    assign w_found    = w_pick[PTRW];
    assign w_win      = w_pick[PTRW-1:0];
    assign w_grant    = w_found ? (NREQ'(1) << w_win) : '0;
    assign w_win_rndx = bus.req_rndx[int'(w_win)*RNDXW +: RNDXW];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr   <= '0;
            r_credit   <= 3'(CREDITS);
            r_mc_cnt   <= '0;
            r_mc_rndx  <= '0;
            r_sau_v    <= 1'b0;
            r_sau_rse  <= '0;
            r_sau_rndx <= '0;
        end else begin
            r_sau_v <= w_found;
            if (w_found) begin
                r_sau_rse  <= bus.req_rse[int'(w_win)*RSEW +: RSEW];
                r_sau_rndx <= w_win_rndx;
                r_rr_ptr   <= (w_win == PTRW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            end
            // A grant and a returned slot in the same cycle cancel out;
            // a return with the pool already full is dropped.
            case ({w_found, bus.wb_ret})
                2'b10:   r_credit <= r_credit - 3'd1;
                2'b01:   if (r_credit != 3'(CREDITS)) r_credit <= r_credit + 3'd1;
                default: r_credit <= r_credit;
            endcase
            if (r_state == ST_IDLE) begin
                if (w_found && bus.req_mc[w_win]) begin
                    r_mc_cnt  <= CNTW'(MCLAT - 1);
                    r_mc_rndx <= w_win_rndx;
                end
            end else begin
                r_mc_cnt <= r_mc_cnt - 1'b1;
            end
        end
    end

    assign bus.grant      = w_grant;
    assign bus.sau_v_o    = r_sau_v;
    assign bus.sau_rse_o  = r_sau_rse;
    assign bus.sau_rndx_o = r_sau_rndx;
    assign bus.busy_o     = w_busy;
endmodule
